// File: rtl/fc_wgt_arbiter_pkg.sv
// Shared constants and types for the fully-connected weight-fetch path.
package fc_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_LEN0   = 2500;
    localparam int unsigned DEF_LEN1   = 13;
    localparam int unsigned DEF_BASE0  = 0;
    localparam int unsigned DEF_BASE1  = 2500;

    localparam int unsigned WGT_BYTES_PER_WORD = 8;

    typedef struct packed {
        logic valid;
        logic idx;
        logic last;
    } tag_t;

endpackage

// File: rtl/fc_wgt_arbiter_if.sv
// Engine request/return and weight-memory signals of the weight-fetch arbiter.
interface fc_wgt_arbiter_if
    import fc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic [1:0]        req;
    logic [1:0]        restart;
    logic [1:0]        gnt;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rdata;
    logic [1:0]        rvalid;
    logic [63:0]       rdata;
    logic [1:0]        pass_done;

    modport master (
        input  req, restart, mem_rdata,
        output gnt, mem_rd_en, mem_addr, rvalid, rdata, pass_done
    );

    modport slave (
        output req, restart, mem_rdata,
        input  gnt, mem_rd_en, mem_addr, rvalid, rdata, pass_done
    );

endinterface

// File: rtl/fc_wgt_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on contention the engine other than `last` wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[0] && (!req[1] || last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/fc_wgt_arbiter.sv
// Shares one weight-memory read port between the layer-0 and layer-1 FC engines,
// keeping a wrapping word pointer per engine and steering data back with a tag.
module fc_wgt_arbiter
    import fc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LEN0   = DEF_LEN0,
    parameter int unsigned LEN1   = DEF_LEN1,
    parameter int unsigned BASE0  = DEF_BASE0,
    parameter int unsigned BASE1  = DEF_BASE1
) (
    input  logic              clk1,
    input  logic              rst_n,
    fc_wgt_arbiter_if.master  bus,
    output logic [ADDR_W-1:0] ptr0,
    output logic [ADDR_W-1:0] ptr1
);

    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              last_q;
    logic              wrap0;
    logic              wrap1;
    logic [ADDR_W-1:0] addr;
    tag_t              tag_q;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // rst_n is active-high despite its name; grants are suppressed while it is held.
    assign gnt   = rst_n ? 2'b00 : arb_gnt;
    assign wrap0 = (ptr0 == ADDR_W'(LEN0 - 1));
    assign wrap1 = (ptr1 == ADDR_W'(LEN1 - 1));

    always_comb begin
        addr = '0;
        if (gnt[0]) begin
            addr = ADDR_W'(BASE0) + ptr0;
        end else if (gnt[1]) begin
            addr = ADDR_W'(BASE1) + ptr1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst_n) begin
            ptr0   <= '0;
            ptr1   <= '0;
            last_q <= 1'b1;
            tag_q  <= '0;
        end else begin
            // restart wins over the increment; a same-cycle grant still reads the old address
            if (bus.restart[0]) begin
                ptr0 <= '0;
            end else if (gnt[0]) begin
                ptr0 <= wrap0 ? '0 : ptr0 + ADDR_W'(1);
            end

            if (bus.restart[1]) begin
                ptr1 <= '0;
            end else if (gnt[1]) begin
                ptr1 <= wrap1 ? '0 : ptr1 + ADDR_W'(1);
            end

            if (|gnt) begin
                last_q <= gnt[1];
            end

            tag_q.valid <= |gnt;
            tag_q.idx   <= gnt[1];
            tag_q.last  <= gnt[1] ? wrap1 : wrap0;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.mem_rd_en = |gnt;
    assign bus.mem_addr  = addr;
    assign bus.rdata     = bus.mem_rdata;

    // In-flight tags are dropped at reset, so nothing returns while reset is held.
    assign bus.rvalid    = rst_n ? 2'b00
                         : {tag_q.valid & tag_q.idx, tag_q.valid & ~tag_q.idx};
    assign bus.pass_done = rst_n ? 2'b00
                         : {tag_q.valid & tag_q.idx & tag_q.last,
                            tag_q.valid & ~tag_q.idx & tag_q.last};

endmodule

// File: tb/tb_fc_wgt_arbiter.sv
// Directed table-driven bench for fc_wgt_arbiter with a one-cycle-latency memory model.
module tb_fc_wgt_arbiter;
    import fc_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic [11:0] ptr0;
    logic [11:0] ptr1;

    always #5 clk1 = ~clk1;

    fc_wgt_arbiter_if #(.ADDR_W(12)) bus ();

    fc_wgt_arbiter #(
        .ADDR_W (12),
        .LEN0   (2500),
        .LEN1   (13),
        .BASE0  (0),
        .BASE1  (2500)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus),
        .ptr0  (ptr0),
        .ptr1  (ptr1)
    );

    function automatic logic [63:0] data_of(input logic [11:0] a);
        return {20'hDEAD0, a, 20'h5EED0, a};
    endfunction

    always @(posedge clk1) begin
        if (bus.mem_rd_en) bus.mem_rdata <= data_of(bus.mem_addr);
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  restart;
        logic [1:0]  gnt;
        logic [11:0] addr;
        logic [1:0]  rv;
        logic [1:0]  pd;
        logic [11:0] p0;
        logic [11:0] p1;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          row      = 0;
    logic [11:0] prev_addr = '0;
    vec_t        tbl [$];

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [1:0] restart,
                                input logic [1:0] gnt, input int addr, input logic [1:0] rv,
                                input logic [1:0] pd, input int p0, input int p1);
        vec_t v;
        v.rst = rst; v.req = req; v.restart = restart; v.gnt = gnt;
        v.addr = 12'(addr); v.rv = rv; v.pd = pd; v.p0 = 12'(p0); v.p1 = 12'(p1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk1);
        #1;
        rst_n       = v.rst;
        bus.req     = v.req;
        bus.restart = v.restart;
        @(negedge clk1);
        chk("gnt", 64'(bus.gnt), 64'(v.gnt));
        chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(|v.gnt));
        chk("mem_addr", 64'(bus.mem_addr), 64'(v.addr));
        chk("rvalid", 64'(bus.rvalid), 64'(v.rv));
        chk("pass_done", 64'(bus.pass_done), 64'(v.pd));
        chk("ptr0", 64'(ptr0), 64'(v.p0));
        chk("ptr1", 64'(ptr1), 64'(v.p1));
        if (v.rv != 2'b00) chk("rdata", bus.rdata, data_of(prev_addr));
        prev_addr = v.addr;
        row++;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.req     = 2'b00;
        bus.restart = 2'b00;
        repeat (2) @(posedge clk1);

        // reset held with both requesting, then contention from reset
        tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0,    2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0,    2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 0,    2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2500, 2'b01, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1,    2'b10, 2'b00, 1, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2501, 2'b01, 2'b00, 2, 1));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 2,    2'b10, 2'b00, 2, 2));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 2502, 2'b01, 2'b00, 3, 2));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0,    2'b10, 2'b00, 3, 3));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0,    2'b00, 2'b00, 3, 3));
        // re-reset, then lone engine-0 stream
        tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0,    2'b00, 2'b00, 3, 3));
        tbl.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0,    2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 0,    2'b00, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 1,    2'b01, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 2,    2'b01, 2'b00, 2, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 3,    2'b01, 2'b00, 3, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 4,    2'b01, 2'b00, 4, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0,    2'b01, 2'b00, 5, 0));
        // advance to ptr0=7, then restart colliding with a grant, then a bare restart
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 5,    2'b00, 2'b00, 5, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 6,    2'b01, 2'b00, 6, 0));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 7,    2'b01, 2'b00, 7, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 0,    2'b01, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0,    2'b01, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 2'b00, 0,    2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0,    2'b00, 2'b00, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // engine-1 wrap: 13 grants end at 2512 with pass_done, then back to 2500
        for (int i = 0; i < 14; i++) begin
            step(mk(0, 2'b10, 2'b00, 2'b10, 2500 + (i % 13),
                    (i == 0) ? 2'b00 : 2'b10, (i == 13) ? 2'b10 : 2'b00, 0, i % 13));
        end
        step(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 1));

        // reset one cycle after a grant suppresses its return; last restarts at 1
        step(mk(0, 2'b01, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 1));
        step(mk(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 1));
        step(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0));
        step(mk(0, 2'b11, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0, 0));
        step(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b01, 2'b00, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_wgt_arbiter.md
# fc_wgt_arbiter

Shares a single 64-bit synchronous weight-memory read port between the two chained fully-connected engines (layer 0 and layer 1). It is the weight-fetch controller between the engines' weight-read requests and the memory. It keeps one word pointer per engine, wraps each pointer at its layer length, and arbitrates round-robin when both engines request in the same cycle. Each returned word is steered back to its owner with a one-cycle tagged valid.

## Interface
Parameters:
- ADDR_W, 12: memory word-address width (64-bit words).
- LEN0, 2500: layer-0 weight length in words.
- LEN1, 13: layer-1 weight length in words.
- BASE0, 0: layer-0 base word address.
- BASE1, 2500: layer-1 base word address.

Ports:
- clk1  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-high (1 = reset); the port keeps the codebase name.
- req  in  2  req[k] = weight-read request from engine k; held high until granted.
- restart  in  2  restart[k] pulse clears pointer k to 0.
- gnt  out  2  one-hot grant, combinational, same cycle as the accepted request.
- mem_rd_en  out  1  memory read strobe; equals |gnt.
- mem_addr  out  ADDR_W  BASEk + ptr[k] of the granted engine; 0 when idle.
- mem_rdata  in  64  memory data, valid the cycle after mem_rd_en.
- rvalid  out  2  one-hot, registered; rvalid[k] marks rdata for engine k.
- rdata  out  64  mem_rdata passed through; meaningful only when |rvalid.
- pass_done  out  2  registered pulse with the rvalid carrying word LENk-1 of engine k.
- ptr0, ptr1  out  ADDR_W  current word pointers, for debug and status.

## Operation
- Arbitration is round-robin over two requesters, with a 1-bit last register `last` (reset 1, so engine 0 wins first).
  - Only req[k] high: grant k.
  - Both high: grant the engine other than `last`.
  - `last` updates to the granted index on every grant.
- At most one grant per cycle. An ungranted request stays pending and must not drop; the arbiter does not buffer it.
- Pointer k on a grant to k:
  - ptr[k] equal to LENk-1: ptr[k] becomes 0 and the returning word is tagged as the last of the pass.
  - Otherwise ptr[k] increments by 1.
- restart[k] sets ptr[k] to 0 and takes priority over the increment.
  - If restart[k] and gnt[k] fall in the same cycle, the read issues at the old address and ptr[k] becomes 0.
- Tag pipeline is one register stage holding {valid, index, last_of_pass}. Its outputs drive rvalid and pass_done.
- Address arithmetic is unsigned in ADDR_W bits. BASEk + LENk must be ≤ 2^ADDR_W; no overflow is checked.
- Reset values: gnt=0, mem_rd_en=0, mem_addr=0, rvalid=0, pass_done=0, ptr0=ptr1=0, last=1. Asserting rst_n mid-operation discards any in-flight tag, so no rvalid follows.

## Timing
- Cycle t: req[k]=1 and the engine wins, so gnt[k]=1, mem_rd_en=1 and mem_addr=BASEk+ptr[k], all combinational.
- Cycle t+1: rvalid[k]=1, rdata=mem_rdata, and ptr[k] shows its updated value.
- Read latency is 1 cycle from grant to data.
- Throughput is one word per cycle in aggregate.
- Both engines requesting continuously receive alternate cycles: 0,1,0,1…
- A lone requester gets back-to-back grants with no bubble.
- rdata is not registered. The memory must hold mem_rdata valid for the cycle after the strobe.

## Structure
- Shared package fc_pkg holds:
  - LEN0/LEN1/BASE0/BASE1 defaults and ADDR_W;
  - the constant WGT_BYTES_PER_WORD=8;
  - a tag struct {valid, idx, last}.
- One sub-module, rr_arb2: two-input round-robin arbiter (req, last in; one-hot gnt out). The pointer and tag logic stays in fc_wgt_arbiter.

## Test plan
- Reset: assert rst_n for 2 cycles with req=2'b11 → gnt=0, mem_rd_en=0 and all outputs 0 during reset. First grant after release goes to engine 0 at mem_addr=0.
- Lone stream: req=2'b01 for 5 cycles → gnt=01 every cycle, mem_addr 0,1,2,3,4. rvalid=01 one cycle later each time, and rdata matches the memory model.
- Contention: req=2'b11 for 6 cycles from reset → gnt sequence 01,10,01,10,01,10. mem_addr 0,2500,1,2501,2,2502.
- Wrap: drive engine 1 for 13 grants → 13th address is 2512. pass_done=10 together with its rvalid, then ptr1=0 and the next address is 2500.
- Restart collision: with ptr0=7, assert restart=01 and gnt=01 in the same cycle → mem_addr=7, then ptr0=0 and the next engine-0 address is 0.
- Reset mid-flight: grant engine 0 at cycle t and assert rst_n at t+1 → no rvalid at t+1 and all pointers read 0 after reset.
